// File: rtl/hilo_unit.sv
// -----------------------------------------------------------------------------
// hilo_unit
//
// Sits between the multicycle divider and the register-file write-back path.
// It turns a divide request into a one-cycle divider start pulse, waits for
// the divider to finish, and commits the remainder/quotient into the
// architectural HI/LO registers. It also handles MTHI/MTLO writes and
// MFHI/MFLO reads, divide-by-zero exceptions, a completion timeout, and the
// busy/stall interlock for the control unit.
//
// Ports
//   clock, reset            : rising-edge clock, asynchronous active-low reset
//   div_req                 : one-cycle divide request
//   div_end_i               : divider done flag (sticky until the next start)
//   div_zero_i              : divider divide-by-zero flag (combinational)
//   div_hi_i / div_lo_i     : divider remainder / quotient
//   mthi_we / mtlo_we, wdata: HI/LO move-to writes
//   rd_req, rd_sel          : HI/LO read request, select (0 = HI, 1 = LO)
//   div_start_o             : one-cycle start pulse to the divider
//   rdata, hi_o, lo_o       : selected register, architectural HI and LO
//   busy, stall             : operation in flight / control unit must hold
//   done_o                  : one-cycle pulse after a commit
//   div_zero_exc, timeout_o : one-cycle registered exception/abort pulses
// -----------------------------------------------------------------------------
module hilo_unit #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             div_req,
  input  logic             div_end_i,
  input  logic             div_zero_i,
  input  logic [WIDTH-1:0] div_hi_i,
  input  logic [WIDTH-1:0] div_lo_i,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_req,
  input  logic             rd_sel,
  output logic             div_start_o,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy,
  output logic             stall,
  output logic             done_o,
  output logic             div_zero_exc,
  output logic             timeout_o
);

  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_zero_exc;
  logic             r_timeout;

  logic             w_commit;
  logic             w_abort;
  logic             w_zero_exc;
  logic             w_idle;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and event decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_next     = r_state;
    w_commit   = 1'b0;
    w_abort    = 1'b0;
    w_zero_exc = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (div_req) begin
          if (div_zero_i) begin
            w_zero_exc = 1'b1;
          end else begin
            w_next = S_LAUNCH;
          end
        end
      end
      // The divider still shows the previous sticky end flag here, so
      // div_end_i is deliberately not looked at in this state.
      S_LAUNCH: begin
        w_next = S_WAIT;
      end
      // A completion on the last allowed cycle takes priority over abort.
      S_WAIT: begin
        if (div_end_i) begin
          w_commit = 1'b1;
          w_next   = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_idle = (r_state == S_IDLE);

  // ---------------------------------------------------------------------------
  // Wait counter, HI/LO registers and registered event pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_zero_exc <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_done     <= w_commit;
      r_zero_exc <= w_zero_exc;
      r_timeout  <= w_abort;

      if (r_state == S_LAUNCH) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + CW'(1);
      end

      // Moves are only accepted in IDLE; a move issued together with
      // div_req lands now and is later overwritten by the commit.
      if (w_commit) begin
        r_hi <= div_hi_i;
        r_lo <= div_lo_i;
      end else if (w_idle) begin
        if (mthi_we) r_hi <= wdata;
        if (mtlo_we) r_lo <= wdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign div_start_o  = (r_state == S_LAUNCH);
  assign busy         = !w_idle;
  assign stall        = busy & (div_req | rd_req | mthi_we | mtlo_we);
  assign hi_o         = r_hi;
  assign lo_o         = r_lo;
  assign rdata        = rd_sel ? r_lo : r_hi;
  assign done_o       = r_done;
  assign div_zero_exc = r_zero_exc;
  assign timeout_o    = r_timeout;

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Sits directly downstream of the multicycle divider and upstream of the register-file write-back path.
- Accepts a divide request from the control unit and issues a one-cycle start pulse to the divider.
- Waits for divider completion and commits the divider's HI/LO results into the architectural HI and LO registers.
- Also handles MTHI/MTLO writes, MFHI/MFLO reads, divide-by-zero exceptions, a completion timeout, and the busy/stall interlock seen by the control unit.

Parameters:
- WIDTH, 32: data width of HI, LO, write data and read data.
- TIMEOUT, 64: maximum number of cycles in WAIT before the operation is aborted.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- div_req  in  1  one-cycle divide request from the control unit.
- div_end_i  in  1  divider completion flag. Level, sticky until the next divider start.
- div_zero_i  in  1  divider divide-by-zero flag. Combinational, valid while divisor operand is stable.
- div_hi_i  in  WIDTH  divider remainder.
- div_lo_i  in  WIDTH  divider quotient.
- mthi_we  in  1  write wdata into HI.
- mtlo_we  in  1  write wdata into LO.
- wdata  in  WIDTH  MTHI/MTLO data.
- rd_req  in  1  MFHI/MFLO read request.
- rd_sel  in  1  read select: 0 = HI, 1 = LO.
- div_start_o  out  1  one-cycle start pulse to the divider.
- rdata  out  WIDTH  selected register value.
- hi_o  out  WIDTH  architectural HI.
- lo_o  out  WIDTH  architectural LO.
- busy  out  1  high in LAUNCH and WAIT.
- stall  out  1  busy AND (div_req OR rd_req OR mthi_we OR mtlo_we). Combinational.
- done_o  out  1  one-cycle pulse after a commit.
- div_zero_exc  out  1  one-cycle registered exception pulse.
- timeout_o  out  1  one-cycle registered pulse on abort.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - HI=0, LO=0, wait counter=0.
  - div_start_o, done_o, div_zero_exc, timeout_o all 0.
  - Reset mid-operation abandons the divide. HI/LO clear to 0, no done_o is produced.
- States: IDLE, LAUNCH, WAIT.
- IDLE:
  - div_req=1 and div_zero_i=1: div_zero_exc=1 next cycle. No launch, HI/LO unchanged, stay IDLE.
  - div_req=1 and div_zero_i=0: go to LAUNCH.
  - mthi_we / mtlo_we: written at the clock edge. Both asserted together write wdata into both registers.
  - A write in the same cycle as div_req is applied, then overwritten at commit.
- LAUNCH: div_start_o=1 for exactly this cycle, counter cleared, go to WAIT.
  - div_end_i is ignored in LAUNCH, because the divider still shows the previous sticky flag.
- WAIT: counter increments every cycle.
  - div_end_i=1: at that edge HI<=div_hi_i, LO<=div_lo_i, done_o=1 next cycle, go to IDLE.
  - Counter reaches TIMEOUT-1 with div_end_i=0: timeout_o=1 next cycle, HI/LO unchanged, go to IDLE.
  - div_end_i=1 on the timeout cycle: the commit wins and no timeout is reported.
- Busy-state requests (LAUNCH or WAIT):
  - div_req, mthi_we and mtlo_we are ignored, and stall=1.
  - The control unit must hold a stalled request until stall drops.
- Reads:
  - rdata = rd_sel ? LO : HI, combinational, in every state.
  - A read in IDLE in the cycle after done_o returns the new value.
  - A read while busy asserts stall, and the returned data must be treated as invalid.
- Latency: with the standard divider, the cycle count from div_req to done_o is fixed.
  - 1 cycle IDLE to LAUNCH, then divider latency (33 edges after start) in WAIT, then 1 cycle for done_o.
- All arithmetic is at width WIDTH. No sign handling; the divider owns signedness.

Test Plan:
- Basic divide: reset, then div_req with A=100, B=7.
  - Required: div_start_o single pulse one cycle later, busy high.
  - Required: done_o pulse, then hi_o=2, lo_o=14, rd_sel=0 gives rdata=2.
- Divide by zero: div_req with div_zero_i=1, HI=5 preloaded.
  - Required: div_zero_exc pulse next cycle, div_start_o stays 0, hi_o=5, busy stays 0.
- Stall: during WAIT assert rd_req, mthi_we with wdata=0xDEAD, and a second div_req.
  - Required: stall=1 each cycle.
  - Required: HI not written, no second div_start_o.
  - Required: after commit HI equals the divider result.
- Timeout: hold div_end_i=0 after launch with TIMEOUT=64.
  - Required: timeout_o pulse 64 cycles after LAUNCH, return to IDLE, HI/LO unchanged, done_o never asserted.
- Stale end flag: div_end_i held 1 from the previous divide through LAUNCH.
  - Required: no commit in LAUNCH; commit only on div_end_i seen in WAIT.
- Reset mid-WAIT: assert reset=0 for 1 cycle at WAIT cycle 10.
  - Required: immediate IDLE, hi_o=lo_o=0, busy=0, no done_o afterwards.
- Concurrent writes: mthi_we=mtlo_we=1, wdata=0x1234 in IDLE.
  - Required: hi_o=lo_o=0x1234.
